// File: rtl/wb_pkg.sv
// ---------------------------------------------------------------------------
// wb_pkg
// Shared types and constants for the register writeback path.
//   WB_ADDR_WIDTH      decoded register address width (32 registers)
//   WB_DATA_WIDTH      register data width
//   WB_REG_ADDR_WIDTH  width of the register block's write address port
//   wb_req_t           one pending register write {addr, data}
//   gnt_t              per-cycle write-port grant decision
// ---------------------------------------------------------------------------
package wb_pkg;

    localparam int WB_ADDR_WIDTH     = 5;
    localparam int WB_DATA_WIDTH     = 16;
    localparam int WB_REG_ADDR_WIDTH = 8;

    typedef struct packed {
        logic [WB_ADDR_WIDTH-1:0] addr;
        logic [WB_DATA_WIDTH-1:0] data;
    } wb_req_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_ALU  = 2'd1,
        GNT_LD   = 2'd2
    } gnt_t;

endpackage

// File: rtl/wb_load_fifo.sv
// ---------------------------------------------------------------------------
// wb_load_fifo
// Circular buffer of pending load writes (wb_req_t). The head entry is read
// combinationally so a load enqueued in one cycle can be granted in the next.
// Every entry's address and an occupancy bit are exported so the top level
// can answer "is a write to register X still in flight" in the same cycle.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   push, push_req enqueue strobe and entry (caller guarantees !full)
//   pop            dequeue strobe (caller guarantees !empty)
//   head           entry at the read pointer
//   count          occupied entries, 0..DEPTH
//   full, empty    occupancy flags
//   entry_addr     destination address of every storage slot
//   entry_valid    slot currently holds a queued entry
// ---------------------------------------------------------------------------
module wb_load_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 push,
    input  wb_req_t                              push_req,
    input  logic                                 pop,
    output wb_req_t                              head,
    output logic [CNT_W-1:0]                     count,
    output logic                                 full,
    output logic                                 empty,
    output logic [DEPTH-1:0][WB_ADDR_WIDTH-1:0]  entry_addr,
    output logic [DEPTH-1:0]                     entry_valid
);

    wb_req_t          mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;

    // Storage has no reset: occupancy is tracked purely by count_reg, so
    // stale contents are never visible after a reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= push_req;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head  = mem[rd_ptr_reg];
    assign count = count_reg;
    assign full  = (count_reg == CNT_W'(DEPTH));
    assign empty = (count_reg == '0);

    // A slot is occupied when its distance from the read pointer (modulo
    // DEPTH) is below the occupancy count.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [PTR_W-1:0] offset;
            assign offset          = PTR_W'(gi) - rd_ptr_reg;
            assign entry_valid[gi] = (CNT_W'(offset) < count_reg);
            assign entry_addr[gi]  = mem[gi].addr;
        end
    endgenerate

endmodule

// File: rtl/reg_writeback_arbiter.sv
// ---------------------------------------------------------------------------
// reg_writeback_arbiter
// Merges ALU results (unbuffered) and load results (queued in wb_load_fifo)
// onto the register block's single write port. ALU traffic has priority, but
// once the FIFO is non-empty at most STARVE_LIMIT consecutive ALU grants are
// allowed before the FIFO head is forced through.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   alu_valid/alu_ready/addr/data   ALU result offer, accepted when granted
//   ld_valid/ld_ready/addr/data     load result offer, accepted when not full
//   wb_we/wb_addr/wb_data           registered write port to register block
//   chk_addr/chk_pending            decode query: write to chk_addr in flight
//   fifo_count                      occupied load FIFO entries
//
// The wb_req_t fields are sized by wb_pkg; ADDR_WIDTH/DATA_WIDTH overrides
// must be matched by the package constants.
// ---------------------------------------------------------------------------
module reg_writeback_arbiter
    import wb_pkg::*;
#(
    parameter int ADDR_WIDTH     = WB_ADDR_WIDTH,
    parameter int DATA_WIDTH     = WB_DATA_WIDTH,
    parameter int REG_ADDR_WIDTH = WB_REG_ADDR_WIDTH,
    parameter int FIFO_DEPTH     = 4,
    parameter int STARVE_LIMIT   = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          alu_valid,
    output logic                          alu_ready,
    input  logic [ADDR_WIDTH-1:0]         alu_addr,
    input  logic [DATA_WIDTH-1:0]         alu_data,
    input  logic                          ld_valid,
    output logic                          ld_ready,
    input  logic [ADDR_WIDTH-1:0]         ld_addr,
    input  logic [DATA_WIDTH-1:0]         ld_data,
    output logic                          wb_we,
    output logic [REG_ADDR_WIDTH-1:0]     wb_addr,
    output logic [DATA_WIDTH-1:0]         wb_data,
    input  logic [ADDR_WIDTH-1:0]         chk_addr,
    output logic                          chk_pending,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int CNT_W    = $clog2(FIFO_DEPTH) + 1;
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    // ------------------------------------------------------------------
    // Load FIFO
    // ------------------------------------------------------------------
    wb_req_t                                 push_req;
    wb_req_t                                 fifo_head;
    logic                                    fifo_push;
    logic                                    fifo_pop;
    logic                                    fifo_full;
    logic                                    fifo_empty;
    logic [CNT_W-1:0]                        fifo_cnt;
    logic [FIFO_DEPTH-1:0][WB_ADDR_WIDTH-1:0] entry_addr;
    logic [FIFO_DEPTH-1:0]                   entry_valid;

    assign push_req.addr = WB_ADDR_WIDTH'(ld_addr);
    assign push_req.data = WB_DATA_WIDTH'(ld_data);

    wb_load_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_load_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (fifo_push),
        .push_req    (push_req),
        .pop         (fifo_pop),
        .head        (fifo_head),
        .count       (fifo_cnt),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .entry_addr  (entry_addr),
        .entry_valid (entry_valid)
    );

    // ------------------------------------------------------------------
    // Grant decision
    // ------------------------------------------------------------------
    gnt_t                gnt;
    logic [STARVE_W-1:0] starve_cnt_reg;

    // starve_cnt saturates at STARVE_MAX, so "!= MAX" is "< LIMIT".
    // Everything is held off while reset is asserted so no handshake can
    // complete against a design that is being cleared.
    always_comb begin
        gnt = GNT_NONE;
        if (rst_n) begin
            if (alu_valid && (fifo_empty || (starve_cnt_reg != STARVE_MAX))) begin
                gnt = GNT_ALU;
            end else if (!fifo_empty) begin
                gnt = GNT_LD;
            end
        end
    end

    assign alu_ready = (gnt == GNT_ALU);
    assign ld_ready  = rst_n && !fifo_full;
    assign fifo_push = ld_valid && ld_ready;
    assign fifo_pop  = (gnt == GNT_LD);

    // Counts ALU grants that overtook a waiting load; an empty FIFO or a
    // load grant means nobody is being starved.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_reg <= '0;
        end else if (fifo_empty || (gnt == GNT_LD)) begin
            starve_cnt_reg <= '0;
        end else if ((gnt == GNT_ALU) && (starve_cnt_reg != STARVE_MAX)) begin
            starve_cnt_reg <= starve_cnt_reg + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Registered write port; address/data hold when idle
    // ------------------------------------------------------------------
    logic                      wb_we_reg;
    logic [REG_ADDR_WIDTH-1:0] wb_addr_reg;
    logic [DATA_WIDTH-1:0]     wb_data_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_we_reg   <= 1'b0;
            wb_addr_reg <= '0;
            wb_data_reg <= '0;
        end else begin
            wb_we_reg <= (gnt != GNT_NONE);
            case (gnt)
                GNT_ALU: begin
                    wb_addr_reg <= REG_ADDR_WIDTH'(alu_addr);
                    wb_data_reg <= alu_data;
                end
                GNT_LD: begin
                    wb_addr_reg <= REG_ADDR_WIDTH'(fifo_head.addr);
                    wb_data_reg <= DATA_WIDTH'(fifo_head.data);
                end
                default: begin
                    wb_addr_reg <= wb_addr_reg;
                    wb_data_reg <= wb_data_reg;
                end
            endcase
        end
    end

    assign wb_we      = wb_we_reg;
    assign wb_addr    = wb_addr_reg;
    assign wb_data    = wb_data_reg;
    assign fifo_count = fifo_cnt;

    // ------------------------------------------------------------------
    // Pending-write query: the write currently on the port, or any queued
    // load, targeting chk_addr. ALU results are never queued, so these two
    // sources cover every write still in flight.
    // ------------------------------------------------------------------
    logic [FIFO_DEPTH-1:0] entry_hit;
    logic                  port_hit;

    genvar gi;
    generate
        for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_hit
            assign entry_hit[gi] = entry_valid[gi] &&
                                   (entry_addr[gi] == WB_ADDR_WIDTH'(chk_addr));
        end
    endgenerate

    assign port_hit    = wb_we_reg && (wb_addr_reg[ADDR_WIDTH-1:0] == chk_addr);
    assign chk_pending = rst_n && (port_hit || (|entry_hit));

endmodule

// File: tb/tb_reg_writeback_arbiter.sv
module tb_reg_writeback_arbiter;

    localparam int AW  = 5;
    localparam int DW  = 16;
    localparam int RAW = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           alu_valid = 1'b0;
    logic           alu_ready;
    logic [AW-1:0]  alu_addr = '0;
    logic [DW-1:0]  alu_data = '0;
    logic           ld_valid = 1'b0;
    logic           ld_ready;
    logic [AW-1:0]  ld_addr = '0;
    logic [DW-1:0]  ld_data = '0;
    logic           wb_we;
    logic [RAW-1:0] wb_addr;
    logic [DW-1:0]  wb_data;
    logic [AW-1:0]  chk_addr = '0;
    logic           chk_pending;
    logic [2:0]     fifo_count;

    always #5 clk = ~clk;

    reg_writeback_arbiter #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .REG_ADDR_WIDTH (RAW),
        .FIFO_DEPTH     (4),
        .STARVE_LIMIT   (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_addr    (alu_addr),
        .alu_data    (alu_data),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .wb_we       (wb_we),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .chk_addr    (chk_addr),
        .chk_pending (chk_pending),
        .fifo_count  (fifo_count)
    );

    typedef struct {
        int addr;
        int data;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   reg_model [32];

    // Expected write-port traffic, in order
    task automatic push_exp(input int a, input int d);
        exp_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic idle();
        alu_valid = 1'b0;
        ld_valid  = 1'b0;
    endtask

    // Monitor: every write on the port is matched against the scoreboard and
    // captured by a register-block model at the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (wb_we === 1'b1) begin
            reg_model[wb_addr[AW-1:0]] = int'(wb_data);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL wb_write: unexpected write addr %0h data %0h, required none",
                         wb_addr, wb_data);
            end else begin
                e = exp_q.pop_front();
                if ((int'(wb_addr) != e.addr) || (int'(wb_data) != e.data)) begin
                    errors++;
                    $display("FAIL wb_write: actual addr %0h data %0h required addr %0h data %0h",
                             wb_addr, wb_data, e.addr, e.data);
                end else begin
                    $display("write addr %0h data %0h", wb_addr, wb_data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required end of stimulus");
        $fatal(1);
    end

    // Load-fill table: 5 loads against continuous ALU traffic
    int fill_lv [13] = '{1,1,1,1,1,1,0,0,0,0,0,0,0};
    int fill_av [13] = '{1,1,1,1,1,1,1,1,1,0,0,0,0};
    int fill_ar [13] = '{1,1,1,1,0,1,1,1,0,0,0,0,0};
    int fill_lr [13] = '{1,1,1,1,0,1,0,0,0,1,1,1,1};
    int fill_fc [13] = '{0,1,2,3,4,3,4,4,4,3,2,1,0};

    int pend_exp [2][4] = '{'{0,1,1,0}, '{0,0,0,0}};

    initial begin
        int ai;
        int li;
        for (int i = 0; i < 32; i++) reg_model[i] = 0;

        // ---------------- power-on reset, inputs active ----------------
        alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 16'h0055;
        ld_valid  = 1'b1; ld_addr  = 5'd2; ld_data  = 16'h0001;
        chk_addr  = 5'd0;
        mid();
        check("rst_wb_we", int'(wb_we), 0);
        check("rst_wb_addr", int'(wb_addr), 0);
        check("rst_wb_data", int'(wb_data), 0);
        check("rst_fifo_count", int'(fifo_count), 0);
        check("rst_alu_ready", int'(alu_ready), 0);
        check("rst_ld_ready", int'(ld_ready), 0);
        check("rst_chk_pending", int'(chk_pending), 0);
        step();
        step();
        rst_n = 1'b1;
        idle();
        mid();
        check("rel_ld_ready", int'(ld_ready), 1);
        check("rel_alu_ready", int'(alu_ready), 0);
        step();

        // ---------------- ALU only ----------------
        alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 16'h1234;
        push_exp(5, 'h1234);
        mid();
        check("alu_only_ready", int'(alu_ready), 1);
        step();
        idle();
        mid();
        check("alu_only_wb_we", int'(wb_we), 1);
        step();
        check("alu_only_regfile_r5", reg_model[5], 'h1234);
        mid();
        check("alu_only_wb_we_drop", int'(wb_we), 0);
        step();

        // ---------------- load only, r1..r4 ----------------
        for (int i = 0; i < 4; i++) begin
            ld_valid = 1'b1; ld_addr = AW'(i + 1); ld_data = DW'('hA1 + i);
            push_exp(i + 1, 'hA1 + i);
            mid();
            check("ld_only_ld_ready", int'(ld_ready), 1);
            check("ld_only_fifo_count", int'(fifo_count), (i == 0) ? 0 : 1);
            step();
        end
        idle();
        mid();
        check("ld_only_fifo_count", int'(fifo_count), 1);
        step();
        mid();
        check("ld_only_fifo_drained", int'(fifo_count), 0);
        step();
        check("ld_only_regfile_r4", reg_model[4], 'hA4);

        // ---------------- load fill against continuous ALU ----------------
        for (int k = 0; k < 4; k++) push_exp(16 + k, 'hB000 + k);
        push_exp(20, 'hC000);
        for (int k = 4; k < 7; k++) push_exp(16 + k, 'hB000 + k);
        for (int k = 1; k < 5; k++) push_exp(20 + k, 'hC000 + k);
        ai = 0;
        li = 0;
        for (int c = 0; c < 13; c++) begin
            alu_valid = fill_av[c][0];
            alu_addr  = AW'(16 + ai);
            alu_data  = DW'('hB000 + ai);
            ld_valid  = fill_lv[c][0];
            ld_addr   = AW'(20 + li);
            ld_data   = DW'('hC000 + li);
            mid();
            if (fill_av[c] != 0) check("fill_alu_ready", int'(alu_ready), fill_ar[c]);
            check("fill_ld_ready", int'(ld_ready), fill_lr[c]);
            check("fill_fifo_count", int'(fifo_count), fill_fc[c]);
            if ((fill_av[c] != 0) && (fill_ar[c] != 0)) ai++;
            if ((fill_lv[c] != 0) && (fill_lr[c] != 0)) li++;
            step();
        end
        idle();
        step();

        // ---------------- pending query ----------------
        for (int run = 0; run < 2; run++) begin
            chk_addr = (run == 0) ? 5'd7 : 5'd8;
            ld_valid = 1'b1; ld_addr = 5'd7; ld_data = DW'('h0770 + run);
            push_exp(7, 'h0770 + run);
            for (int p = 0; p < 4; p++) begin
                mid();
                check((run == 0) ? "pend_r7" : "pend_r8", int'(chk_pending), pend_exp[run][p]);
                step();
                idle();
            end
        end

        // ---------------- simultaneous enqueue / dequeue ----------------
        push_exp(10, 'hD0);
        push_exp(12, 'hD1);
        push_exp(11, 'hE1);
        push_exp(13, 'hE2);
        push_exp(14, 'hE3);
        alu_valid = 1'b1; alu_addr = 5'd10; alu_data = 16'h00D0;
        ld_valid  = 1'b1; ld_addr  = 5'd11; ld_data  = 16'h00E1;
        mid();
        check("sim_fifo_count_s0", int'(fifo_count), 0);
        step();
        alu_addr = 5'd12; alu_data = 16'h00D1;
        ld_addr  = 5'd13; ld_data  = 16'h00E2;
        mid();
        check("sim_alu_ready_s1", int'(alu_ready), 1);
        check("sim_fifo_count_s1", int'(fifo_count), 1);
        step();
        alu_valid = 1'b0;
        ld_addr = 5'd14; ld_data = 16'h00E3;
        mid();
        check("sim_fifo_count_s2", int'(fifo_count), 2);
        check("sim_ld_ready_s2", int'(ld_ready), 1);
        step();
        idle();
        mid();
        check("sim_fifo_count_held", int'(fifo_count), 2);
        step();
        mid();
        check("sim_fifo_count_s4", int'(fifo_count), 1);
        step();
        mid();
        check("sim_fifo_count_s5", int'(fifo_count), 0);
        step();
        step();

        // ---------------- reset mid-stream with 3 loads queued ----------------
        for (int r = 0; r < 3; r++) begin
            alu_valid = 1'b1; alu_addr = AW'(17 + r); alu_data = DW'('hF0 + r);
            ld_valid  = 1'b1; ld_addr  = AW'(25 + r); ld_data  = DW'('h90 + r);
            // the third ALU write is cleared by reset before it is seen
            if (r < 2) push_exp(17 + r, 'hF0 + r);
            mid();
            check("mrst_fill_count", int'(fifo_count), r);
            step();
        end
        rst_n = 1'b0;
        chk_addr = 5'd25;
        for (int r = 0; r < 2; r++) begin
            mid();
            check("mrst_wb_we", int'(wb_we), 0);
            check("mrst_wb_addr", int'(wb_addr), 0);
            check("mrst_wb_data", int'(wb_data), 0);
            check("mrst_fifo_count", int'(fifo_count), 0);
            check("mrst_ld_ready", int'(ld_ready), 0);
            check("mrst_alu_ready", int'(alu_ready), 0);
            check("mrst_chk_pending", int'(chk_pending), 0);
            step();
        end
        rst_n = 1'b1;
        idle();
        mid();
        check("mrst_rel_ld_ready", int'(ld_ready), 1);
        check("mrst_rel_fifo_count", int'(fifo_count), 0);
        check("mrst_rel_chk_pending", int'(chk_pending), 0);
        step();
        for (int r = 0; r < 4; r++) begin
            mid();
            check("mrst_no_stale_write", int'(wb_we), 0);
            step();
        end

        check("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
